// File: rtl/keypad_pkg.sv
// Shared types and register map for the keypad scanner and its scan-code FIFO.
`default_nettype none

package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_SCAN     = 3'd2,
    ST_PUSH     = 3'd3,
    ST_HOLD     = 3'd4
  } state_e;

  localparam int CODE_W = 8;
  typedef logic [CODE_W-1:0] code_t;

  localparam logic [2:0] ADDR_KEY_DATA = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_CTRL     = 3'd4;

  localparam int STAT_NONEMPTY  = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_HELD      = 3;
  localparam int STAT_COUNT_LSB = 4;

  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_IRQ_EN  = 2;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_fifo.sv
// Synchronous scan-code FIFO with flush; a pop frees room for a push in the same cycle.
`default_nettype none

module keypad_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: synchroniser, debounce/scan FSM, scan-code FIFO and CPU register file.
`default_nettype none

module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int SCAN_DWELL      = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            keyboardCtrl_i,
  input  logic            read_enable_i,
  input  logic            write_enable_i,
  input  logic [2:0]      address_i,
  input  logic [15:0]     write_data_i,
  input  logic [COLS-1:0] column_i,
  output logic [ROWS-1:0] row_o,
  output logic [15:0]     read_data_output_o,
  output logic            irq_o
);

  localparam int DW  = cnt_width(DEBOUNCE_CYCLES);
  localparam int SW  = cnt_width(SCAN_DWELL);
  localparam int PW  = cnt_width(REPEAT_CYCLES);
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] DWELL_END = SW'(SCAN_DWELL);
  localparam logic [PW-1:0] REP_LAST  = PW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  logic [COLS-1:0] col_meta_q, col_sync_q;
  logic            col_idle;

  state_e          state_q, state_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [SW-1:0]   dwell_q, dwell_d;
  logic [PW-1:0]   rep_q, rep_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  code_t           code_q, code_d;
  logic [CW-1:0]   hit_col;
  logic            scan_push;

  logic            rd_sel, wr_ctrl, flush, clr_ovf;
  logic            fifo_pop, fifo_full, fifo_empty;
  code_t           fifo_head;
  logic [FCW-1:0]  fifo_count;
  logic            ovf_q, ovf_d;
  logic            irq_en_q, irq_q, held;
  logic [15:0]     rdata_d, rdata_q, status_w, ctrl_w;
  logic            unused_wdata;

  assign unused_wdata = ^write_data_i[15:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
    end else begin
      col_meta_q <= column_i;
      col_sync_q <= col_meta_q;
    end
  end

  assign col_idle = &col_sync_q;

  always_comb begin
    hit_col = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!col_sync_q[i]) hit_col = CW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    dwell_d   = dwell_q;
    rep_d     = rep_q;
    row_idx_d = row_idx_q;
    code_d    = code_q;
    scan_push = 1'b0;
    row_o     = '0;
    case (state_q)
      ST_IDLE: begin
        deb_cnt_d = '0;
        if (!col_idle) state_d = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (col_idle) begin
          state_d   = ST_IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = ST_SCAN;
          row_idx_d = '0;
          dwell_d   = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      ST_SCAN: begin
        row_o = ~(ROWS'(1) << row_idx_q);
        // Sample one cycle past the dwell so the 2-flop synchroniser sees this row.
        if (dwell_q == DWELL_END) begin
          if (!col_idle) begin
            code_d  = code_t'(int'(row_idx_q) * COLS + int'(hit_col));
            state_d = ST_PUSH;
          end else if (row_idx_q == ROW_LAST) begin
            state_d = ST_IDLE;
          end else begin
            row_idx_d = row_idx_q + 1'b1;
            dwell_d   = '0;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_PUSH: begin
        scan_push = 1'b1;
        deb_cnt_d = '0;
        rep_d     = '0;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        if (col_idle) begin
          if (deb_cnt_q == DEB_LAST) state_d = ST_IDLE;
          else                       deb_cnt_d = deb_cnt_q + 1'b1;
        end else begin
          deb_cnt_d = '0;
          if (REPEAT_CYCLES > 0) begin
            if (rep_q == REP_LAST) begin
              scan_push = 1'b1;
              rep_d     = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      deb_cnt_q <= '0;
      dwell_q   <= '0;
      rep_q     <= '0;
      row_idx_q <= '0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      dwell_q   <= dwell_d;
      rep_q     <= rep_d;
      row_idx_q <= row_idx_d;
      code_q    <= code_d;
    end
  end

  assign rd_sel  = read_enable_i & keyboardCtrl_i;
  assign wr_ctrl = write_enable_i & keyboardCtrl_i & (address_i == ADDR_CTRL);
  assign flush   = wr_ctrl & write_data_i[CTRL_FLUSH];
  assign clr_ovf = wr_ctrl & write_data_i[CTRL_CLR_OVF];
  assign held    = (state_q == ST_PUSH) || (state_q == ST_HOLD);

  keypad_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (scan_push),
    .pop_i   (fifo_pop),
    .flush_i (flush),
    .data_i  (code_q),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    status_w = '0;
    status_w[STAT_NONEMPTY]          = ~fifo_empty;
    status_w[STAT_FULL]              = fifo_full;
    status_w[STAT_OVERFLOW]          = ovf_q;
    status_w[STAT_HELD]              = held;
    status_w[STAT_COUNT_LSB +: 4]    = 4'(fifo_count);
    ctrl_w = '0;
    ctrl_w[CTRL_IRQ_EN]              = irq_en_q;
  end

  always_comb begin
    rdata_d  = '0;
    fifo_pop = 1'b0;
    if (rd_sel) begin
      case (address_i)
        ADDR_KEY_DATA: begin
          if (!fifo_empty) begin
            rdata_d  = {1'b1, 7'b0, fifo_head};
            fifo_pop = 1'b1;
          end
        end
        ADDR_STATUS: rdata_d = status_w;
        ADDR_CTRL:   rdata_d = ctrl_w;
        default:     rdata_d = '0;
      endcase
    end
  end

  // A push into a full FIFO is only lost when no pop frees a slot; a flush discards it silently.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (scan_push && fifo_full && !fifo_pop && !flush) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
      if (wr_ctrl) irq_en_q <= write_data_i[CTRL_IRQ_EN];
      irq_q   <= irq_en_q & ~fifo_empty;
    end
  end

  assign read_data_output_o = rdata_q;
  assign irq_o              = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_fifo.sv
// Randomised keypad presses against a queue-based model of the scan-code FIFO and registers.
`default_nettype none

module tb_keypad_scan_fifo;

  localparam int ROWS = 4, COLS = 4, DEB = 8, DWELL = 2, DEPTH = 4, REP = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_a = 1'b0, cs_b = 1'b0, re = 1'b0, we = 1'b0;
  logic [2:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] keys = '0;
  logic [3:0]  row_a, row_b, col_a, col_b;
  logic [15:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  always #5 clk = ~clk;

  // A pressed key pulls its column low whenever its row is driven low.
  function automatic logic [3:0] key_cols(input logic [15:0] k, input logic [3:0] rows);
    logic [3:0] c;
    c = '1;
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < COLS; j++)
        if (k[r*COLS+j] && !rows[r]) c[j] = 1'b0;
    return c;
  endfunction

  assign col_a = key_cols(keys, row_a);
  assign col_b = key_cols(keys, row_b);

  keypad_scan_fifo #(.ROWS(ROWS), .COLS(COLS), .DEBOUNCE_CYCLES(DEB), .SCAN_DWELL(DWELL),
                     .FIFO_DEPTH(DEPTH), .REPEAT_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .keyboardCtrl_i(cs_a), .read_enable_i(re),
    .write_enable_i(we), .address_i(addr), .write_data_i(wdata), .column_i(col_a),
    .row_o(row_a), .read_data_output_o(rd_a), .irq_o(irq_a));

  keypad_scan_fifo #(.ROWS(ROWS), .COLS(COLS), .DEBOUNCE_CYCLES(DEB), .SCAN_DWELL(DWELL),
                     .FIFO_DEPTH(DEPTH), .REPEAT_CYCLES(REP)) dut_rep (
    .clk(clk), .rst_n(rst_n), .keyboardCtrl_i(cs_b), .read_enable_i(re),
    .write_enable_i(we), .address_i(addr), .write_data_i(wdata), .column_i(col_b),
    .row_o(row_b), .read_data_output_o(rd_b), .irq_o(irq_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: pending codes, sticky overflow, interrupt enable.
  int   mq[$];
  logic movf = 1'b0;
  logic mirq = 1'b0;

  function automatic int exp_code(input logic [15:0] m);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m[r*COLS+c]) return r * COLS + c;
    return -1;
  endfunction

  task automatic model_push(input int code);
    if (code >= 0) begin
      if (mq.size() < DEPTH) mq.push_back(code);
      else movf = 1'b1;
    end
  endtask

  function automatic logic [15:0] model_status();
    return {8'h00, 4'(mq.size()), 1'b0, movf, mq.size() == DEPTH, mq.size() != 0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [15:0] m, input int hold);
    keys = m;
    tick(hold);
    keys = '0;
    tick(24);
  endtask

  // tgt: 0 = normal instance, 1 = auto-repeat instance, 2 = nobody selected
  task automatic bus_rd(input int tgt, input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    cs_a = (tgt == 0); cs_b = (tgt == 1); re = 1'b1; addr = a;
    @(negedge clk);
    d = (tgt == 1) ? rd_b : rd_a;
    cs_a = 1'b0; cs_b = 1'b0; re = 1'b0; addr = '0;
  endtask

  task automatic bus_wr(input int tgt, input logic [15:0] v);
    @(negedge clk);
    cs_a = (tgt == 0); cs_b = (tgt == 1); we = 1'b1; addr = 3'd4; wdata = v;
    @(negedge clk);
    cs_a = 1'b0; cs_b = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic wr_ctrl_a(input logic [15:0] v);
    bus_wr(0, v);
    if (v[0]) movf = 1'b0;
    if (v[1]) mq.delete();
    mirq = v[2];
  endtask

  task automatic rd_key_a(input string tag);
    logic [15:0] d, e;
    bus_rd(0, 3'd0, d);
    e = (mq.size() != 0) ? {8'h80, 8'(mq.pop_front())} : 16'h0000;
    check(tag, d, e);
  endtask

  task automatic chk_status_a(input string tag);
    logic [15:0] d;
    bus_rd(0, 3'd2, d);
    check(tag, d, model_status());
    check({tag, "_irq"}, {15'b0, irq_a}, {15'b0, mirq && (mq.size() != 0)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] d, e, m;
    logic [2:0]  a;
    int          k, base, nr;
    logic        found;

    tick(3);
    check("rst_row", {12'b0, row_a}, 16'h0000);
    check("rst_rdata", rd_a, 16'h0000);
    check("rst_irq", {15'b0, irq_a}, 16'h0000);
    rst_n = 1'b1;
    tick(2);
    chk_status_a("rst_status");

    // Single press, row 2 / column 1
    press(16'h0200, 50);
    model_push(exp_code(16'h0200));
    rd_key_a("t1_key");
    rd_key_a("t1_empty");
    check("t1_irq", {15'b0, irq_a}, 16'h0000);

    // Short bounce must not register
    keys = 16'h0001;
    tick(5);
    keys = '0;
    tick(24);
    chk_status_a("bounce_status");

    // Random presses (single keys and pairs), random reads and clears
    for (int it = 0; it < 16; it++) begin
      k = $urandom_range(0, 15);
      m = 16'(1) << k;
      if ($urandom_range(0, 1) == 1) m = m | (16'(1) << $urandom_range(0, 15));
      press(m, $urandom_range(40, 70));
      model_push(exp_code(m));
      nr = $urandom_range(0, 2);
      for (int j = 0; j < nr; j++) rd_key_a("rnd_key");
      if ($urandom_range(0, 3) == 0) wr_ctrl_a(16'h0001);
      a = 3'($urandom_range(1, 7));
      bus_rd(0, a, d);
      e = (a == 3'd2) ? model_status() : (a == 3'd4) ? {13'b0, mirq, 2'b00} : 16'h0000;
      check("rnd_reg", d, e);
      chk_status_a("rnd_status");
    end

    // Unselected read returns zero and pops nothing
    bus_rd(2, 3'd0, d);
    check("nosel_rd", d, 16'h0000);
    chk_status_a("nosel_status");

    // Five distinct presses into a depth-4 FIFO
    wr_ctrl_a(16'h0003);
    base = $urandom_range(0, 15);
    for (int i = 0; i < 5; i++) begin
      k = (base + 3 * i) % 16;
      press(16'(1) << k, 45);
      model_push(k);
    end
    chk_status_a("t3_full");
    for (int i = 0; i < 4; i++) rd_key_a("t3_key");
    chk_status_a("t3_drained");
    wr_ctrl_a(16'h0001);
    chk_status_a("t3_ovf_clr");

    // Interrupt raise and drop
    wr_ctrl_a(16'h0004);
    bus_rd(0, 3'd4, d);
    check("ctrl_rd", d, {13'b0, mirq, 2'b00});
    k = $urandom_range(0, 15);
    keys = 16'(1) << k;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (irq_a) found = 1'b1;
    end
    check("irq_rise", {15'b0, found}, 16'h0001);
    tick(20);
    keys = '0;
    tick(24);
    model_push(k);
    bus_rd(0, 3'd0, d);
    check("irq_key", d, {8'h80, 8'(mq.pop_front())});
    check("irq_at_data", {15'b0, irq_a}, 16'h0001);
    @(negedge clk);
    check("irq_drop", {15'b0, irq_a}, 16'h0000);
    wr_ctrl_a(16'h0000);

    // Auto-repeat instance: one press held long yields repeated codes capped by the FIFO
    bus_wr(1, 16'h0003);
    bus_rd(1, 3'd2, d);
    check("rep_flushed", d, 16'h0000);
    k = $urandom_range(0, 15);
    press(16'(1) << k, 130);
    model_push(k);
    bus_rd(1, 3'd2, d);
    check("rep_status", d, 16'h0047);
    for (int i = 0; i < 4; i++) begin
      bus_rd(1, 3'd0, d);
      check("rep_key", d, {8'h80, 8'(k)});
    end
    bus_rd(1, 3'd2, d);
    check("rep_empty", d, 16'h0004);
    chk_status_a("norep_status");

    // Asynchronous reset in the middle of a scan
    wr_ctrl_a(16'h0004);
    m = 16'(1) << $urandom_range(0, 15);
    press(m, 50);
    model_push(exp_code(m));
    chk_status_a("pre_rst_status");
    keys = 16'h1000;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (row_a != 4'b0000) found = 1'b1;
    end
    check("scan_reached", {15'b0, found}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    check("arst_row", {12'b0, row_a}, 16'h0000);
    check("arst_rdata", rd_a, 16'h0000);
    check("arst_irq", {15'b0, irq_a}, 16'h0000);
    keys = '0;
    tick(3);
    rst_n = 1'b1;
    mq.delete();
    movf = 1'b0;
    mirq = 1'b0;
    tick(24);
    chk_status_a("post_rst_status");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
